// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, timeout poison value
// and watchdog counter width.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam logic [31:0] POISON_DAT = 32'hDEADDEAD;

    // Wide enough for the largest legal TIMEOUT (255).
    localparam int WD_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Two-way request selector, purely combinational (zero latency).
// With fixed_prio set, port 0 wins whenever it requests; otherwise the port named by ptr wins if it requests.
module rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       fixed_prio,
    output logic       win,
    output logic       vld
);

    always_comb begin
        vld = |req;
        if (fixed_prio) begin
            win = ~req[0];
        end else begin
            win = req[ptr] ? ptr : ~ptr;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU (port 0) and a debug/loader master (port 1).
// Grant 1 cycle after request; losing/waiting port sees stall until its one-cycle done pulse.
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              done0,
    output logic              stall0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              done1,
    output logic              stall1,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err,
    output logic              owner
);

    arb_state_t        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic              pick_win;
    logic              pick_vld;
    logic              wd_expired;
    logic [DATA_W-1:0] resp_dat;

    rr_pick u_pick (
        .req        ({req1, req0}),
        .ptr        (ptr_q),
        .fixed_prio (FIXED_PRIO != 0),
        .win        (pick_win),
        .vld        (pick_vld)
    );

    assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
    // An ack on the final watchdog cycle takes precedence over the timeout.
    assign resp_dat   = mem_ack ? mem_rdata : DATA_W'(POISON_DAT);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        wd_d        = wd_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    owner_d     = pick_win;
                    mem_we_d    = pick_win ? we1 : we0;
                    mem_addr_d  = pick_win ? addr1 : addr0;
                    mem_wdata_d = pick_win ? wdata1 : wdata0;
                    mem_req_d   = 1'b1;
                    wd_d        = '0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                wd_d = wd_q + WD_W'(1);
                if (mem_ack || wd_expired) begin
                    mem_req_d = 1'b0;
                    err_d     = ~mem_ack;
                    if (owner_q) begin
                        rdata1_d = resp_dat;
                        done1_d  = 1'b1;
                    end else begin
                        rdata0_d = resp_dat;
                        done0_d  = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ptr_d   = ~owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err_q       <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
        end
    end

    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign stall0    = req0 & ~done0_q;
    assign stall1    = req1 & ~done1_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance share one stimulus stream
// and are compared every cycle against a transaction-level model, plus literal spot checks.
module tb_dmem_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, mem_ack = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0, mem_rdata = '0;

    // Index 0: round-robin instance, index 1: fixed-priority instance.
    logic [31:0] rdata0_o[2], rdata1_o[2], mem_addr_o[2], mem_wdata_o[2];
    logic        done0_o[2], done1_o[2], stall0_o[2], stall1_o[2];
    logic        mem_req_o[2], mem_we_o[2], err_o[2], owner_o[2];

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(rdata0_o[0]), .done0(done0_o[0]), .stall0(stall0_o[0]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(rdata1_o[0]), .done1(done1_o[0]), .stall1(stall1_o[0]),
        .mem_req(mem_req_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
        .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .err(err_o[0]), .owner(owner_o[0])
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(rdata0_o[1]), .done0(done0_o[1]), .stall0(stall0_o[1]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(rdata1_o[1]), .done1(done1_o[1]), .stall1(stall1_o[1]),
        .mem_req(mem_req_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
        .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .err(err_o[1]), .owner(owner_o[1])
    );

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [inst %0d] t=%0t: got %h, required %h", nm, inst, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // in_flight: a grant was issued and the memory has not finished; age counts BUSY cycles (1-based).
    bit          m_inflight[2] = '{0, 0};
    bit          m_closing[2]  = '{0, 0};
    int          m_age[2]      = '{0, 0};
    logic        m_ptr[2]      = '{0, 0};
    logic        e_owner[2]    = '{0, 0};
    logic        e_mem_req[2]  = '{0, 0};
    logic        e_we[2]       = '{0, 0};
    logic [31:0] e_addr[2]     = '{0, 0};
    logic [31:0] e_wdata[2]    = '{0, 0};
    logic [31:0] e_rd0[2]      = '{0, 0};
    logic [31:0] e_rd1[2]      = '{0, 0};
    logic        e_done0[2]    = '{0, 0};
    logic        e_done1[2]    = '{0, 0};
    logic        e_err[2]      = '{0, 0};

    task automatic model_step();
        logic        w;
        logic [31:0] result;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_inflight[i] = 0; m_closing[i] = 0; m_age[i] = 0; m_ptr[i] = 0;
                e_owner[i] = 0; e_mem_req[i] = 0; e_we[i] = 0; e_addr[i] = 0; e_wdata[i] = 0;
                e_rd0[i] = 0; e_rd1[i] = 0; e_done0[i] = 0; e_done1[i] = 0; e_err[i] = 0;
            end else begin
                e_done0[i] = 0; e_done1[i] = 0; e_err[i] = 0;
                if (m_closing[i]) begin
                    m_closing[i] = 0;
                    m_ptr[i] = ~e_owner[i];
                end else if (m_inflight[i]) begin
                    m_age[i] = m_age[i] + 1;
                    if (mem_ack || m_age[i] == TIMEOUT) begin
                        result = mem_ack ? mem_rdata : 32'hDEADDEAD;
                        e_err[i] = !mem_ack;
                        if (e_owner[i]) begin e_rd1[i] = result; e_done1[i] = 1; end
                        else begin e_rd0[i] = result; e_done0[i] = 1; end
                        m_inflight[i] = 0; m_closing[i] = 1; e_mem_req[i] = 0;
                    end
                end else if (req0 || req1) begin
                    if (i == 1) w = req0 ? 1'b0 : 1'b1;
                    else w = (m_ptr[i] ? req1 : req0) ? m_ptr[i] : ~m_ptr[i];
                    e_owner[i] = w;
                    e_we[i]    = w ? we1 : we0;
                    e_addr[i]  = w ? addr1 : addr0;
                    e_wdata[i] = w ? wdata1 : wdata0;
                    e_mem_req[i] = 1; m_inflight[i] = 1; m_age[i] = 0;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            model_step();
        end
    end

    // ---------------- per-cycle comparison ----------------
    int done1_cnt[2] = '{0, 0};
    int err_cnt[2]   = '{0, 0};

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (done1_o[i] === 1'b1) done1_cnt[i]++;
                if (err_o[i] === 1'b1) err_cnt[i]++;
                if (chk_en) begin
                    chk("mem_req", i, mem_req_o[i], e_mem_req[i]);
                    chk("owner", i, owner_o[i], e_owner[i]);
                    chk("done0", i, done0_o[i], e_done0[i]);
                    chk("done1", i, done1_o[i], e_done1[i]);
                    chk("err", i, err_o[i], e_err[i]);
                    chk("rdata0", i, rdata0_o[i], e_rd0[i]);
                    chk("rdata1", i, rdata1_o[i], e_rd1[i]);
                    chk("stall0", i, stall0_o[i], req0 & ~e_done0[i]);
                    chk("stall1", i, stall1_o[i], req1 & ~e_done1[i]);
                    if (e_mem_req[i]) begin
                        chk("mem_we", i, mem_we_o[i], e_we[i]);
                        chk("mem_addr", i, mem_addr_o[i], e_addr[i]);
                        chk("mem_wdata", i, mem_wdata_o[i], e_wdata[i]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mem_req(output bit seen);
        seen = 0;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (mem_req_o[0] === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk("mem_req_rise", 0, 32'(seen), 1);
    endtask

    // Pulses mem_ack on BUSY cycle k; snapshots owner/wdata/addr on BUSY cycle 1.
    task automatic ack_at(input int k, input logic [31:0] dat,
                          output logic own_rr, output logic own_fp,
                          output logic [31:0] wd_rr, output logic [31:0] wd_fp,
                          output logic [31:0] ad_rr);
        bit seen;
        wait_mem_req(seen);
        own_rr = owner_o[0]; own_fp = owner_o[1];
        wd_rr = mem_wdata_o[0]; wd_fp = mem_wdata_o[1]; ad_rr = mem_addr_o[0];
        if (seen) begin
            for (int j = 1; j < k; j++) tick();
            mem_ack = 1'b1;
            mem_rdata = dat;
            tick();
            mem_ack = 1'b0;
            mem_rdata = 32'h0;
        end
    endtask

    logic        o_rr, o_fp;
    logic [31:0] wd_rr, wd_fp, ad_rr;
    int          busy_n;
    bit          seen_rise;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("reset_mem_req", 0, mem_req_o[0], 0);
        chk("reset_rdata0", 0, rdata0_o[0], 32'h0);
        reset = 1'b1;

        // Both ports write continuously: round-robin alternates, fixed priority starves port 1.
        req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'hAAAA;
        req1 = 1; we1 = 1; addr1 = 32'h24; wdata1 = 32'hBBBB;
        for (int k = 0; k < 4; k++) begin
            ack_at(1, 32'h0, o_rr, o_fp, wd_rr, wd_fp, ad_rr);
            chk("rr_owner_seq", 0, o_rr, (k % 2 == 1) ? 1 : 0);
            chk("rr_wdata_seq", 0, wd_rr, (k % 2 == 1) ? 32'hBBBB : 32'hAAAA);
            chk("fp_owner_seq", 1, o_fp, 0);
            chk("fp_wdata_seq", 1, wd_fp, 32'hAAAA);
        end
        @(negedge clk);
        chk("fp_stall1_held", 1, stall1_o[1], 1);
        chk("fp_done1_never", 1, done1_cnt[1], 0);
        tick();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;

        // Timeout on a port-1 read that is never acknowledged.
        req1 = 1; addr1 = 32'h40;
        wait_mem_req(seen_rise);
        busy_n = 1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (mem_req_o[0] !== 1'b1) break;
            if (t > 0) busy_n++;
        end
        chk("timeout_busy_cycles", 0, busy_n, 16);
        chk("timeout_err", 0, err_o[0], 1);
        chk("timeout_done1", 0, done1_o[0], 1);
        chk("timeout_rdata1", 0, rdata1_o[0], 32'hDEADDEAD);
        tick();
        req1 = 0;
        @(negedge clk);
        chk("timeout_err_once", 0, err_cnt[0], 1);

        // Ack on the last watchdog cycle wins over the timeout.
        req1 = 1; addr1 = 32'h44;
        ack_at(16, 32'h55, o_rr, o_fp, wd_rr, wd_fp, ad_rr);
        @(negedge clk);
        chk("lastcyc_done1", 0, done1_o[0], 1);
        chk("lastcyc_err", 0, err_o[0], 0);
        chk("lastcyc_rdata1", 0, rdata1_o[0], 32'h55);
        tick();
        req1 = 0;

        // Single port-0 read, ack on BUSY cycle 3.
        tick();
        req0 = 1; we0 = 0; addr0 = 32'h10;
        ack_at(3, 32'h12345678, o_rr, o_fp, wd_rr, wd_fp, ad_rr);
        chk("read_addr", 0, ad_rr, 32'h10);
        @(negedge clk);
        chk("read_done0", 0, done0_o[0], 1);
        chk("read_rdata0", 0, rdata0_o[0], 32'h12345678);
        tick();
        req0 = 0;
        @(negedge clk);
        chk("read_done0_pulse", 0, done0_o[0], 0);
        chk("read_rdata0_hold", 0, rdata0_o[0], 32'h12345678);

        // Reset during BUSY; pointer (now 1 for the round-robin instance) must return to 0.
        req1 = 1; addr1 = 32'h60;
        wait_mem_req(seen_rise);
        tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_mem_req", i, mem_req_o[i], 0);
            chk("rst_owner", i, owner_o[i], 0);
            chk("rst_rdata0", i, rdata0_o[i], 32'h0);
            chk("rst_rdata1", i, rdata1_o[i], 32'h0);
            chk("rst_done1", i, done1_o[i], 0);
            chk("rst_err", i, err_o[i], 0);
        end
        req0 = 1; addr0 = 32'h70;
        tick();
        reset = 1'b1;
        ack_at(1, 32'h77, o_rr, o_fp, wd_rr, wd_fp, ad_rr);
        chk("post_rst_owner", 0, o_rr, 0);
        @(negedge clk);
        chk("post_rst_rdata0", 0, rdata0_o[0], 32'h77);
        tick();
        req0 = 0;
        ack_at(1, 32'h99, o_rr, o_fp, wd_rr, wd_fp, ad_rr);
        chk("post_rst_owner1", 0, o_rr, 1);
        @(negedge clk);
        chk("post_rst_rdata1", 0, rdata1_o[0], 32'h99);
        tick();
        req1 = 0;
        chk("err_total", 0, err_cnt[0], 1);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "global timeout");
    end

endmodule
